// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (I) and data (D) requesters.
// Data wins by default. A starvation counter forces a fetch grant after STARVE_MAX data grants.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hlt,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_rdy,
    output logic [15:0] i_data,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rdy,
    output logic [15:0] d_rdata,
    output logic [15:0] m_addr,
    output logic        m_re,
    output logic        m_we,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, stateNext;
    logic        ownerD;
    logic        isWrite;
    logic [7:0]  tmoCnt;
    logic [2:0]  starveCnt;
    logic        iWant, dWant, grantD, grantI, timeoutHit;

    always_comb begin
        iWant      = i_req & ~hlt;
        dWant      = d_re | d_we;
        grantD     = (state == IDLE) && dWant && !(iWant && (starveCnt == STARVE_LIM));
        grantI     = (state == IDLE) && !grantD && iWant;
        timeoutHit = (state == BUSY) && !m_valid && (tmoCnt == TMO_LAST);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantD || grantI) stateNext = BUSY;
            BUSY:    if (m_valid || timeoutHit) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // tmoCnt is zero only in the first BUSY cycle, so it doubles as the strobe qualifier
    assign m_re      = (state == BUSY) && (tmoCnt == 8'd0) && !isWrite;
    assign m_we      = (state == BUSY) && (tmoCnt == 8'd0) && isWrite;
    assign i_rdy     = (state == RESP) && !ownerD;
    assign d_rdy     = (state == RESP) && ownerD;
    assign stall_if  = i_req & ~i_rdy;
    assign stall_mem = (d_re | d_we) & ~d_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ownerD    <= 1'b0;
            isWrite   <= 1'b0;
            tmoCnt    <= '0;
            starveCnt <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_data    <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            state <= stateNext;

            if (grantD || grantI) begin
                ownerD  <= grantD;
                isWrite <= grantD && d_we;
                m_addr  <= grantD ? d_addr : i_addr;
                if (grantD) m_wdata <= d_wdata;
                tmoCnt  <= '0;
                // simultaneous read and write is served as a write but flagged
                if (grantD && d_re && d_we) err <= 1'b1;
            end else if (state == BUSY) begin
                tmoCnt <= tmoCnt + 8'd1;
            end

            if (state == IDLE) begin
                if (grantI || !i_req)
                    starveCnt <= '0;
                else if (grantD && iWant && (starveCnt < STARVE_LIM))
                    starveCnt <= starveCnt + 3'd1;
            end

            if (state == BUSY) begin
                if (m_valid) begin
                    if (!ownerD)
                        i_data <= m_rdata;
                    else if (!isWrite)
                        d_rdata <= m_rdata;
                end else if (timeoutHit) begin
                    err <= 1'b1;
                    if (ownerD) d_rdata <= '0;
                    else        i_data  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hlt;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_rdy;
    logic [15:0] i_data;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_rdy;
    logic [15:0] d_rdata;
    logic [15:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .hlt(hlt),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem [0:65535];
    int          memLat  = 1;
    bit          memMute = 1'b0;
    bit          spur    = 1'b0;
    bit          pend    = 1'b0;
    int          pendCnt = 0;
    int          lastLat = 0;
    logic [15:0] pendAddr;
    bit          pendWe;

    typedef struct { int c; bit we; logic [15:0] a; logic [15:0] wd; } strobe_t;
    typedef struct { int c; bit isD; logic [15:0] data; } rdy_t;
    strobe_t sq[$];
    rdy_t    rq[$];

    // advance one cycle, play the memory, and log strobes and responses
    task automatic tick();
        strobe_t s;
        rdy_t    r;
        @(posedge clk);
        #1;
        cyc++;
        m_valid = 1'b0;
        m_rdata = 16'($urandom);
        if (m_re || m_we) begin
            pend = 1'b1; pendCnt = memLat; lastLat = memLat;
            pendAddr = m_addr; pendWe = m_we;
            if (m_we) mem[m_addr] = m_wdata;
            s.c = cyc; s.we = m_we; s.a = m_addr; s.wd = m_wdata;
            sq.push_back(s);
        end else if (pend) begin
            pendCnt--;
        end
        if (pend && pendCnt <= 0) begin
            pend = 1'b0;
            if (!memMute) begin
                m_valid = 1'b1;
                m_rdata = pendWe ? 16'($urandom) : mem[pendAddr];
            end
        end
        if (spur) begin
            m_valid = 1'b1;
            m_rdata = 16'hDEAD;
        end
        if (i_rdy) begin r.c = cyc; r.isD = 1'b0; r.data = i_data; rq.push_back(r); end
        if (d_rdy) begin r.c = cyc; r.isD = 1'b1; r.data = d_rdata; rq.push_back(r); end
    endtask

    task automatic doReset();
        rst_n = 1'b0; i_req = 1'b0; d_re = 1'b0; d_we = 1'b0; hlt = 1'b0;
        spur = 1'b0; memMute = 1'b0; pend = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        sq.delete(); rq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if ({i_rdy, d_rdy, m_re, m_we, err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {i_rdy, d_rdy, m_re, m_we, err}); end
        total++; if (m_addr !== 16'h0) begin bad++; $display("FAIL reset_m_addr got=%h want=0000", m_addr); end
        total++; if (m_wdata !== 16'h0) begin bad++; $display("FAIL reset_m_wdata got=%h want=0000", m_wdata); end
        total++; if (i_data !== 16'h0) begin bad++; $display("FAIL reset_i_data got=%h want=0000", i_data); end
        total++; if (d_rdata !== 16'h0) begin bad++; $display("FAIL reset_d_rdata got=%h want=0000", d_rdata); end
        total++; if ({stall_if, stall_mem} !== 2'b00) begin bad++; $display("FAIL reset_stall_idle got=%b want=00", {stall_if, stall_mem}); end
        i_req = 1'b1; d_re = 1'b1;
        #1;
        total++; if ({stall_if, stall_mem} !== 2'b11) begin bad++; $display("FAIL reset_stall_req got=%b want=11", {stall_if, stall_mem}); end
        i_req = 1'b0; d_re = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        total++; if ({i_rdy, d_rdy, m_re, m_we} !== 4'b0) begin bad++; $display("FAIL post_reset_quiet got=%b want=0000", {i_rdy, d_rdy, m_re, m_we}); end
        sq.delete(); rq.delete();
    endtask

    task automatic test_single_fetch();
        int c0;
        bit stallMid;
        bit stallAtRdy;
        memLat = 1;
        mem[16'h0010] = 16'hA5A5;
        sq.delete(); rq.delete();
        i_req = 1'b1; i_addr = 16'h0010;
        c0 = cyc;
        stallMid = 1'b0; stallAtRdy = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 2) stallMid = stall_if;
            if (i_rdy) begin stallAtRdy = stall_if; i_req = 1'b0; end
        end
        total++; if (sq.size() != 1) begin bad++; $display("FAIL fetch_strobe_count got=%0d want=1", sq.size()); end
        else begin
            total++; if (sq[0].c - c0 != 1) begin bad++; $display("FAIL fetch_strobe_cycle got=%0d want=1", sq[0].c - c0); end
            total++; if ({sq[0].we, sq[0].a} !== {1'b0, 16'h0010}) begin bad++; $display("FAIL fetch_strobe got=%b/%h want=0/0010", sq[0].we, sq[0].a); end
        end
        total++; if (rq.size() != 1) begin bad++; $display("FAIL fetch_rdy_count got=%0d want=1", rq.size()); end
        else begin
            total++; if (rq[0].isD !== 1'b0 || rq[0].c - c0 != 3) begin bad++; $display("FAIL fetch_rdy got=isD%0d@%0d want=isD0@3", rq[0].isD, rq[0].c - c0); end
            total++; if (rq[0].data !== 16'hA5A5) begin bad++; $display("FAIL fetch_data got=%h want=a5a5", rq[0].data); end
        end
        total++; if ({stallMid, stallAtRdy} !== 2'b10) begin bad++; $display("FAIL fetch_stall got=%b want=10", {stallMid, stallAtRdy}); end
        total++; if (i_data !== 16'hA5A5) begin bad++; $display("FAIL fetch_data_hold got=%h want=a5a5", i_data); end
    endtask

    task automatic test_d_priority();
        int c0;
        memLat = 1;
        mem[16'h0100] = 16'h7E01;
        sq.delete(); rq.delete();
        i_req = 1'b1; i_addr = 16'h0100;
        d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        c0 = cyc;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (d_rdy) d_we = 1'b0;
            if (i_rdy) i_req = 1'b0;
        end
        total++; if (sq.size() != 2) begin bad++; $display("FAIL prio_strobe_count got=%0d want=2", sq.size()); end
        else begin
            total++; if (sq[0].c - c0 != 1 || {sq[0].we, sq[0].a, sq[0].wd} !== {1'b1, 16'h0040, 16'h1234}) begin bad++; $display("FAIL prio_d_strobe got=@%0d %b/%h/%h want=@1 1/0040/1234", sq[0].c - c0, sq[0].we, sq[0].a, sq[0].wd); end
            total++; if (sq[1].c - c0 != 5 || {sq[1].we, sq[1].a} !== {1'b0, 16'h0100}) begin bad++; $display("FAIL prio_i_strobe got=@%0d %b/%h want=@5 0/0100", sq[1].c - c0, sq[1].we, sq[1].a); end
        end
        total++; if (rq.size() != 2) begin bad++; $display("FAIL prio_rdy_count got=%0d want=2", rq.size()); end
        else begin
            total++; if (rq[0].isD !== 1'b1 || rq[0].c - c0 != 3) begin bad++; $display("FAIL prio_d_rdy got=isD%0d@%0d want=isD1@3", rq[0].isD, rq[0].c - c0); end
            total++; if (rq[1].isD !== 1'b0 || rq[1].c - c0 != 7 || rq[1].data !== 16'h7E01) begin bad++; $display("FAIL prio_i_rdy got=isD%0d@%0d %h want=isD0@7 7e01", rq[1].isD, rq[1].c - c0, rq[1].data); end
        end
        total++; if (mem[16'h0040] !== 16'h1234) begin bad++; $display("FAIL prio_write_mem got=%h want=1234", mem[16'h0040]); end
    endtask

    task automatic test_starvation();
        int dN, iN;
        bit expD;
        logic [15:0] expA;
        memLat = 0;
        sq.delete(); rq.delete();
        d_re = 1'b1; d_addr = 16'h1000;
        i_req = 1'b1; i_addr = 16'h2000;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (d_rdy) d_addr = d_addr + 16'd1;
            if (i_rdy) i_addr = i_addr + 16'd1;
        end
        d_re = 1'b0; i_req = 1'b0;
        repeat (6) tick();
        total++; if (sq.size() < 10) begin bad++; $display("FAIL starve_grants got=%0d want>=10", sq.size()); end
        else begin
            dN = 0; iN = 0;
            for (int k = 0; k < 10; k++) begin
                expD = (k % 5) != 4;
                expA = expD ? 16'(16'h1000 + dN) : 16'(16'h2000 + iN);
                if (expD) dN++; else iN++;
                total++; if (sq[k].a !== expA) begin bad++; $display("FAIL starve_order grant%0d got=%h want=%h", k, sq[k].a, expA); end
                if (k > 0) begin
                    total++; if (sq[k].c - sq[k-1].c != 3) begin bad++; $display("FAIL starve_spacing grant%0d got=%0d want=3", k, sq[k].c - sq[k-1].c); end
                end
            end
        end
    endtask

    task automatic test_timeout();
        int c0;
        bit errBefore;
        logic [15:0] iHold;
        memLat = 1; memMute = 1'b1;
        sq.delete(); rq.delete();
        d_re = 1'b1; d_addr = 16'h0300;
        c0 = cyc;
        errBefore = 1'b1;
        for (int n = 1; n <= 270; n++) begin
            tick();
            if (n == 255) errBefore = err;
            if (d_rdy) d_re = 1'b0;
        end
        total++; if (errBefore !== 1'b0) begin bad++; $display("FAIL tmo_err_early got=%b want=0", errBefore); end
        total++; if (sq.size() != 1) begin bad++; $display("FAIL tmo_strobe_count got=%0d want=1", sq.size()); end
        total++; if (rq.size() != 1) begin bad++; $display("FAIL tmo_rdy_count got=%0d want=1", rq.size()); end
        else begin
            total++; if (rq[0].isD !== 1'b1 || rq[0].c - c0 != 256) begin bad++; $display("FAIL tmo_rdy got=isD%0d@%0d want=isD1@256", rq[0].isD, rq[0].c - c0); end
            total++; if (rq[0].data !== 16'h0000) begin bad++; $display("FAIL tmo_data got=%h want=0000", rq[0].data); end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", err); end
        memMute = 1'b0;
        iHold = i_data;
        spur = 1'b1;
        repeat (3) tick();
        spur = 1'b0;
        repeat (3) tick();
        total++; if (rq.size() != 1) begin bad++; $display("FAIL late_valid_rdy got=%0d want=1", rq.size()); end
        total++; if ({d_rdata, i_data} !== {16'h0000, iHold}) begin bad++; $display("FAIL late_valid_data got=%h/%h want=0000/%h", d_rdata, i_data, iHold); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    endtask

    task automatic test_halt();
        int c0, c1;
        memLat = 2;
        mem[16'h0002] = 16'h0BEE;
        mem[16'h0400] = 16'h4A11;
        sq.delete(); rq.delete();
        hlt = 1'b1;
        i_req = 1'b1; i_addr = 16'h0400;
        d_re = 1'b1; d_addr = 16'h0002;
        c0 = cyc;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (d_rdy) d_re = 1'b0;
        end
        total++; if (sq.size() != 1) begin bad++; $display("FAIL halt_strobe_count got=%0d want=1", sq.size()); end
        else begin
            total++; if ({sq[0].we, sq[0].a} !== {1'b0, 16'h0002}) begin bad++; $display("FAIL halt_d_strobe got=%b/%h want=0/0002", sq[0].we, sq[0].a); end
        end
        total++; if (rq.size() != 1) begin bad++; $display("FAIL halt_rdy_count got=%0d want=1", rq.size()); end
        else begin
            total++; if (rq[0].isD !== 1'b1 || rq[0].c - c0 != 4 || rq[0].data !== 16'h0BEE) begin bad++; $display("FAIL halt_d_rdy got=isD%0d@%0d %h want=isD1@4 0bee", rq[0].isD, rq[0].c - c0, rq[0].data); end
        end
        total++; if (stall_if !== 1'b1) begin bad++; $display("FAIL halt_stall_if got=%b want=1", stall_if); end
        hlt = 1'b0;
        c1 = cyc;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (m_re) hlt = 1'b1;
            if (i_rdy) i_req = 1'b0;
        end
        hlt = 1'b0;
        total++; if (sq.size() != 2 || rq.size() != 2) begin bad++; $display("FAIL unhalt_counts got=%0d/%0d want=2/2", sq.size(), rq.size()); end
        else begin
            total++; if (sq[1].c - c1 != 1 || sq[1].a !== 16'h0400) begin bad++; $display("FAIL unhalt_i_strobe got=@%0d %h want=@1 0400", sq[1].c - c1, sq[1].a); end
            total++; if (rq[1].isD !== 1'b0 || rq[1].c - c1 != 4 || rq[1].data !== 16'h4A11) begin bad++; $display("FAIL hlt_mid_fetch got=isD%0d@%0d %h want=isD0@4 4a11", rq[1].isD, rq[1].c - c1, rq[1].data); end
        end
    endtask

    task automatic test_reset_mid();
        int c1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_hold_pre_reset got=%b want=1", err); end
        memLat = 5;
        sq.delete(); rq.delete();
        d_re = 1'b1; d_addr = 16'h0600;
        tick(); tick();
        rst_n = 1'b0; d_re = 1'b0;
        #1;
        total++; if ({i_rdy, d_rdy, m_re, m_we, err} !== 5'b0) begin bad++; $display("FAIL midreset_flags got=%b want=00000", {i_rdy, d_rdy, m_re, m_we, err}); end
        total++; if ({m_addr, m_wdata, i_data, d_rdata} !== 64'h0) begin bad++; $display("FAIL midreset_data got=%h want=0", {m_addr, m_wdata, i_data, d_rdata}); end
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        total++; if (rq.size() != 0 || sq.size() != 1) begin bad++; $display("FAIL midreset_abort got=rdy%0d strobe%0d want=rdy0 strobe1", rq.size(), sq.size()); end
        total++; if ({d_rdata, err} !== 17'h0) begin bad++; $display("FAIL midreset_stray_valid got=%h/%b want=0000/0", d_rdata, err); end
        memLat = 1;
        mem[16'h0700] = 16'h5117;
        i_req = 1'b1; i_addr = 16'h0700;
        c1 = cyc;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (i_rdy) i_req = 1'b0;
        end
        total++; if (rq.size() != 1) begin bad++; $display("FAIL post_reset_rdy_count got=%0d want=1", rq.size()); end
        else begin
            total++; if (rq[0].isD !== 1'b0 || rq[0].c - c1 != 3 || rq[0].data !== 16'h5117) begin bad++; $display("FAIL post_reset_fetch got=isD%0d@%0d %h want=isD0@3 5117", rq[0].isD, rq[0].c - c1, rq[0].data); end
        end
    endtask

    task automatic test_random();
        logic [15:0] refMem [0:255];
        bit          mBusy, mOwnD, mWe, mErr;
        int          mFree, mStrC, mRdyC, mStarve;
        logic [15:0] mA, mWd, mData, mLastDR;
        bit          expI, expD, expS, iW, dW;
        int          op;
        doReset();
        for (int a = 0; a < 256; a++) refMem[a] = mem[a];
        mBusy = 1'b0; mOwnD = 1'b0; mWe = 1'b0; mErr = 1'b0;
        mFree = 0; mStrC = 0; mRdyC = 0; mStarve = 0;
        mA = '0; mWd = '0; mData = '0; mLastDR = '0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            expI = mBusy && (cyc == mRdyC) && !mOwnD;
            expD = mBusy && (cyc == mRdyC) && mOwnD;
            expS = mBusy && (cyc == mStrC);
            total++; if (i_rdy !== expI) begin bad++; $display("FAIL rnd_i_rdy cyc%0d got=%b want=%b", cyc, i_rdy, expI); end
            total++; if (d_rdy !== expD) begin bad++; $display("FAIL rnd_d_rdy cyc%0d got=%b want=%b", cyc, d_rdy, expD); end
            total++; if ((m_re | m_we) !== expS) begin bad++; $display("FAIL rnd_strobe cyc%0d got=%b want=%b", cyc, m_re | m_we, expS); end
            if (expS) begin
                total++; if ({m_we, m_addr} !== {mWe, mA}) begin bad++; $display("FAIL rnd_strobe_addr cyc%0d got=%b/%h want=%b/%h", cyc, m_we, m_addr, mWe, mA); end
                if (mWe) begin
                    total++; if (m_wdata !== mWd) begin bad++; $display("FAIL rnd_wdata cyc%0d got=%h want=%h", cyc, m_wdata, mWd); end
                end
                mRdyC = cyc + lastLat + 1;
            end
            if (expI) begin
                total++; if (i_data !== mData) begin bad++; $display("FAIL rnd_i_data cyc%0d got=%h want=%h", cyc, i_data, mData); end
            end
            if (expD) begin
                if (!mWe) mLastDR = mData;
                total++; if (d_rdata !== mLastDR) begin bad++; $display("FAIL rnd_d_rdata cyc%0d got=%h want=%h", cyc, d_rdata, mLastDR); end
            end
            total++; if (err !== mErr) begin bad++; $display("FAIL rnd_err cyc%0d got=%b want=%b", cyc, err, mErr); end
            total++; if ({stall_if, stall_mem} !== {i_req && !expI, (d_re || d_we) && !expD}) begin bad++; $display("FAIL rnd_stall cyc%0d got=%b%b want=%b%b", cyc, stall_if, stall_mem, i_req && !expI, (d_re || d_we) && !expD); end
            if (expI || expD) begin mBusy = 1'b0; mFree = cyc + 1; end

            if (i_req && i_rdy) begin
                if ($urandom_range(1) == 0) i_req = 1'b0;
                else i_addr = 16'($urandom_range(63));
            end else if (!i_req && $urandom_range(2) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom_range(63));
            end
            if ((d_re || d_we) && d_rdy) begin
                d_re = 1'b0; d_we = 1'b0;
            end else if (!(d_re || d_we) && $urandom_range(2) == 0) begin
                op = int'($urandom_range(15));
                d_re = (op == 0) || (op < 8);
                d_we = (op == 0) || (op >= 8);
                d_addr = 16'($urandom_range(63));
                d_wdata = 16'($urandom);
            end
            if ($urandom_range(19) == 0) hlt = ~hlt;
            memLat = int'($urandom_range(3));

            if (!mBusy && cyc >= mFree) begin
                iW = i_req && !hlt;
                dW = d_re || d_we;
                if (dW && !(iW && mStarve == 4)) begin
                    mBusy = 1'b1; mOwnD = 1'b1; mWe = d_we; mA = d_addr; mWd = d_wdata;
                    if (d_re && d_we) mErr = 1'b1;
                    if (mWe) refMem[mA[7:0]] = mWd;
                    else     mData = refMem[mA[7:0]];
                    if (iW && mStarve < 4) mStarve++;
                end else if (iW) begin
                    mBusy = 1'b1; mOwnD = 1'b0; mWe = 1'b0; mA = i_addr;
                    mData = refMem[mA[7:0]];
                    mStarve = 0;
                end
                if (!i_req) mStarve = 0;
                if (mBusy) begin mStrC = cyc + 1; mRdyC = -1; end
            end
        end
        i_req = 1'b0; d_re = 1'b0; d_we = 1'b0; hlt = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst_n = 1'b0; hlt = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_valid = 1'b0; m_rdata = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A3C;
        test_reset();
        test_single_fetch();
        test_d_priority();
        test_starvation();
        test_timeout();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
